// File: rtl/aqua_pump_arbiter.sv
// aqua_pump_arbiter: round-robin owner of a shared water pump for two vending units.
// Each grant runs the pump for (5 or 10 liters) * CYCLES_PER_LITER clock cycles.
// The owner may abort by dropping its request while the pump runs.
// All outputs are registered. The next-state logic computes every output's next
// value, and the register process captures it.
// Optional feature macro: AQUA_TANK_LEVEL_EN adds the refill input, the tank_level
// output and the reject_a/reject_b outputs. Without it the tank is unlimited.
module aqua_pump_arbiter #(
    parameter int CYCLES_PER_LITER = 4,
    parameter int TANK_CAP         = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       vol_a,
    input  logic       vol_b,
`ifdef AQUA_TANK_LEVEL_EN
    input  logic       refill,
    output logic [7:0] tank_level,
    output logic       reject_a,
    output logic       reject_b,
`endif
    output logic       grant_a,
    output logic       grant_b,
    output logic       done_a,
    output logic       done_b,
    output logic       pump_on,
    output logic [3:0] liters_left,
    output logic       busy
);

    // Elaboration-time guards on the parameter ranges
    if (CYCLES_PER_LITER < 1 || CYCLES_PER_LITER > 255) begin : g_bad_cpl
        $error("aqua_pump_arbiter: CYCLES_PER_LITER must be 1..255");
    end
    if (TANK_CAP < 0 || TANK_CAP > 255) begin : g_bad_cap
        $error("aqua_pump_arbiter: TANK_CAP must fit in 8 bits");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        PUMP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(CYCLES_PER_LITER - 1);
`ifdef AQUA_TANK_LEVEL_EN
    localparam logic [7:0] CAP8 = 8'(TANK_CAP);
`endif

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic       owner_b;
    logic       owner_b_nx;
    logic       last_b;
    logic       last_b_nx;
    logic       grant_a_nx;
    logic       grant_b_nx;
    logic       done_a_nx;
    logic       done_b_nx;
    logic       pump_nx;
    logic [3:0] liters_nx;
`ifdef AQUA_TANK_LEVEL_EN
    logic [7:0] tank_nx;
    logic       reject_a_nx;
    logic       reject_b_nx;
`endif

    logic [3:0] vol_liters;
    logic       owner_req;
    logic       a_wins;

    // Liters requested by the current owner.
    // Only consumed in GRANT, so later vol changes have no effect.
    assign vol_liters = (owner_b ? vol_b : vol_a) ? 4'd10 : 4'd5;
    // Request line of whichever unit currently owns the pump
    assign owner_req  = owner_b ? req_b : req_a;
    // A wins when it is the only requester, or on a tie when B was served last
    assign a_wins     = req_a && (!req_b || last_b);

    // Next-state and next-output computation for the four-state transaction FSM
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        owner_b_nx  = owner_b;
        last_b_nx   = last_b;
        grant_a_nx  = grant_a;
        grant_b_nx  = grant_b;
        done_a_nx   = 1'b0;
        done_b_nx   = 1'b0;
        pump_nx     = pump_on;
        liters_nx   = liters_left;
`ifdef AQUA_TANK_LEVEL_EN
        tank_nx     = tank_level;
        reject_a_nx = 1'b0;
        reject_b_nx = 1'b0;
`endif
        case (state)
            IDLE: begin
                grant_a_nx = 1'b0;
                grant_b_nx = 1'b0;
                pump_nx    = 1'b0;
                cnt_nx     = '0;
`ifdef AQUA_TANK_LEVEL_EN
                if (refill) begin
                    tank_nx = CAP8;
                end
`endif
                if (req_a || req_b) begin
                    state_nx   = GRANT;
                    owner_b_nx = !a_wins;
                    grant_a_nx = a_wins;
                    grant_b_nx = !a_wins;
                end
            end
            GRANT: begin
`ifdef AQUA_TANK_LEVEL_EN
                if ({4'd0, vol_liters} > tank_level) begin
                    state_nx    = IDLE;
                    grant_a_nx  = 1'b0;
                    grant_b_nx  = 1'b0;
                    last_b_nx   = owner_b;
                    reject_a_nx = !owner_b;
                    reject_b_nx = owner_b;
                end else begin
                    state_nx  = PUMP;
                    pump_nx   = 1'b1;
                    liters_nx = vol_liters;
                    cnt_nx    = '0;
                end
`else
                state_nx  = PUMP;
                pump_nx   = 1'b1;
                liters_nx = vol_liters;
                cnt_nx    = '0;
`endif
            end
            PUMP: begin
                if (!owner_req) begin
                    state_nx   = IDLE;
                    pump_nx    = 1'b0;
                    liters_nx  = '0;
                    cnt_nx     = '0;
                    grant_a_nx = 1'b0;
                    grant_b_nx = 1'b0;
                    last_b_nx  = owner_b;
                end else if (cnt == CNT_MAX) begin
                    cnt_nx    = '0;
                    liters_nx = liters_left - 4'd1;
`ifdef AQUA_TANK_LEVEL_EN
                    tank_nx   = tank_level - 8'd1;
`endif
                    if (liters_left == 4'd1) begin
                        state_nx  = DONE;
                        pump_nx   = 1'b0;
                        done_a_nx = !owner_b;
                        done_b_nx = owner_b;
                    end
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            DONE: begin
                state_nx   = IDLE;
                grant_a_nx = 1'b0;
                grant_b_nx = 1'b0;
                last_b_nx  = owner_b;
            end
            default: begin
                state_nx   = IDLE;
                grant_a_nx = 1'b0;
                grant_b_nx = 1'b0;
                pump_nx    = 1'b0;
                liters_nx  = '0;
                cnt_nx     = '0;
            end
        endcase
    end

    // State and registered outputs; reset stops the pump at once and gives A the next tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            owner_b     <= 1'b0;
            last_b      <= 1'b1;
            grant_a     <= 1'b0;
            grant_b     <= 1'b0;
            done_a      <= 1'b0;
            done_b      <= 1'b0;
            pump_on     <= 1'b0;
            liters_left <= '0;
            busy        <= 1'b0;
`ifdef AQUA_TANK_LEVEL_EN
            tank_level  <= CAP8;
            reject_a    <= 1'b0;
            reject_b    <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            owner_b     <= owner_b_nx;
            last_b      <= last_b_nx;
            grant_a     <= grant_a_nx;
            grant_b     <= grant_b_nx;
            done_a      <= done_a_nx;
            done_b      <= done_b_nx;
            pump_on     <= pump_nx;
            liters_left <= liters_nx;
            busy        <= (state_nx != IDLE);
`ifdef AQUA_TANK_LEVEL_EN
            tank_level  <= tank_nx;
            reject_a    <= reject_a_nx;
            reject_b    <= reject_b_nx;
`endif
        end
    end

endmodule

// File: tb/tb_aqua_pump_arbiter.sv
// Self-checking bench for aqua_pump_arbiter.
// Directed scenario tasks plus a randomized run against a transaction-level model
// that tracks the remaining pump cycles of each dispense.
module tb_aqua_pump_arbiter;
    localparam int CPL = 4;
`ifdef AQUA_TANK_LEVEL_EN
    localparam int CAP = 12;
`else
    localparam int CAP = 200;
`endif
    localparam int P_IDLE  = 0;
    localparam int P_GRANT = 1;
    localparam int P_PUMP  = 2;
    localparam int P_DONE  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b, vol_a, vol_b;
    logic       grant_a, grant_b, done_a, done_b, pump_on, busy;
    logic [3:0] liters_left;
`ifdef AQUA_TANK_LEVEL_EN
    logic       refill;
    logic [7:0] tank_level;
    logic       reject_a, reject_b;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state: phase, owner, last served, remaining pump cycles
    int m_phase;
    int m_rem;
    int m_liters;
    bit m_owner_b, m_last_b, m_grant_a, m_grant_b, m_done_a, m_done_b, m_pump;

    aqua_pump_arbiter #(.CYCLES_PER_LITER(CPL), .TANK_CAP(CAP)) dut (
        .clk(clk),
        .reset(reset),
        .req_a(req_a),
        .req_b(req_b),
        .vol_a(vol_a),
        .vol_b(vol_b),
`ifdef AQUA_TANK_LEVEL_EN
        .refill(refill),
        .tank_level(tank_level),
        .reject_a(reject_a),
        .reject_b(reject_b),
`endif
        .grant_a(grant_a),
        .grant_b(grant_b),
        .done_a(done_a),
        .done_b(done_b),
        .pump_on(pump_on),
        .liters_left(liters_left),
        .busy(busy)
    );

    // Free-running clock
    initial forever #5 clk = ~clk;

    task automatic model_reset();
        m_phase = P_IDLE; m_rem = 0; m_liters = 0;
        m_owner_b = 0; m_last_b = 1;
        m_grant_a = 0; m_grant_b = 0; m_done_a = 0; m_done_b = 0; m_pump = 0;
    endtask

    task automatic model_step();
        m_done_a = 0;
        m_done_b = 0;
        case (m_phase)
            P_IDLE: if (req_a || req_b) begin
                m_owner_b = req_b && (!req_a || !m_last_b);
                m_grant_a = !m_owner_b;
                m_grant_b = m_owner_b;
                m_phase   = P_GRANT;
            end
            P_GRANT: begin
                m_liters = (m_owner_b ? vol_b : vol_a) ? 10 : 5;
                m_rem    = m_liters * CPL;
                m_pump   = 1;
                m_phase  = P_PUMP;
            end
            P_PUMP: if (!(m_owner_b ? req_b : req_a)) begin
                m_pump = 0; m_liters = 0; m_grant_a = 0; m_grant_b = 0;
                m_last_b = m_owner_b; m_phase = P_IDLE;
            end else begin
                m_rem    = m_rem - 1;
                m_liters = (m_rem + CPL - 1) / CPL;
                if (m_rem == 0) begin
                    m_pump = 0; m_done_a = !m_owner_b; m_done_b = m_owner_b;
                    m_phase = P_DONE;
                end
            end
            default: begin
                m_grant_a = 0; m_grant_b = 0; m_last_b = m_owner_b; m_phase = P_IDLE;
            end
        endcase
    endtask

    task automatic apply_reset();
        reset = 0; req_a = 0; req_b = 0; vol_a = 0; vol_b = 0;
`ifdef AQUA_TANK_LEVEL_EN
        refill = 0;
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 0; req_a = 1; req_b = 1; vol_a = 1; vol_b = 1;
`ifdef AQUA_TANK_LEVEL_EN
        refill = 0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({grant_a, grant_b, done_a, done_b, pump_on, busy, liters_left} !== 10'd0) begin
                failures++;
                $display("[TB] FAIL reset_outputs got=%b expected=%b",
                         {grant_a, grant_b, done_a, done_b, pump_on, busy, liters_left}, 10'd0);
            end
        end
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        checks++;
        if ({grant_a, grant_b} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL reset_tie_priority got=%b expected=10", {grant_a, grant_b});
        end
    endtask

    task automatic test_single_dispense();
        int pump_cnt = 0;
        int done_cnt = 0;
        bit seen_done = 0;
        bit finished = 0;
        bit first = 1;
        bit bad_b = 0;
        apply_reset();
        req_a = 1; vol_a = 0;
        @(posedge clk); #1;
        checks++;
        if ({grant_a, grant_b, pump_on, busy} !== 4'b1001) begin
            failures++;
            $display("[TB] FAIL single_grant got=%b expected=1001", {grant_a, grant_b, pump_on, busy});
        end
        for (int i = 0; i < 60 && !finished; i++) begin
            @(posedge clk); #1;
            if (grant_b || done_b) bad_b = 1;
            if (seen_done) begin
                checks++;
                if ({grant_a, busy} !== 2'b00) begin
                    failures++;
                    $display("[TB] FAIL single_release got=%b expected=00", {grant_a, busy});
                end
                finished = 1;
            end else begin
                if (pump_on) begin
                    if (first) begin
                        checks++;
                        if (liters_left !== 4'd5) begin
                            failures++;
                            $display("[TB] FAIL single_start_liters got=%0d expected=5", liters_left);
                        end
                    end
                    first = 0;
                    pump_cnt++;
                end
                if (done_a) begin
                    done_cnt++;
                    seen_done = 1;
                    req_a = 0;
                    checks++;
                    if ({grant_a, liters_left} !== 5'b1_0000) begin
                        failures++;
                        $display("[TB] FAIL single_done_state got=%b expected=10000", {grant_a, liters_left});
                    end
                end
            end
        end
        checks++;
        if (!finished) begin
            failures++;
            $display("[TB] FAIL single_timeout got=no_release expected=release");
        end
        checks++;
        if (pump_cnt != 20 || done_cnt != 1) begin
            failures++;
            $display("[TB] FAIL single_counts got=pump%0d/done%0d expected=pump20/done1", pump_cnt, done_cnt);
        end
        checks++;
        if (bad_b) begin
            failures++;
            $display("[TB] FAIL single_nonowner got=b_active expected=b_idle");
        end
    endtask

    task automatic test_back_to_back();
        int n_grants = 0;
        int first_pump = 0;
        bit [2:0] owners_b = '0;
        bit prev_any = 0;
        bit both = 0;
        apply_reset();
        req_a = 1; req_b = 1; vol_a = 1; vol_b = 1;
        for (int i = 0; i < 200 && n_grants < 3; i++) begin
            @(posedge clk); #1;
            if (grant_a && grant_b) both = 1;
            if ((grant_a || grant_b) && !prev_any) begin
                owners_b[n_grants] = grant_b;
                n_grants++;
            end
            prev_any = grant_a || grant_b;
            if (n_grants == 1 && pump_on) first_pump++;
        end
        checks++;
        if (n_grants != 3) begin
            failures++;
            $display("[TB] FAIL tie_grants got=%0d expected=3", n_grants);
        end
        checks++;
        if (owners_b !== 3'b010) begin
            failures++;
            $display("[TB] FAIL tie_order got=%b expected=010 (bit0 first, 1=B)", owners_b);
        end
        checks++;
        if (first_pump != 40) begin
            failures++;
            $display("[TB] FAIL tie_first_pump got=%0d expected=40", first_pump);
        end
        checks++;
        if (both) begin
            failures++;
            $display("[TB] FAIL tie_exclusive got=both_granted expected=one_grant");
        end
    endtask

    task automatic test_abort();
        int pumps = 0;
        bit bad_done = 0;
        apply_reset();
        req_b = 1; vol_b = 0;
        @(posedge clk); #1;
        req_a = 1;
        for (int i = 0; i < 30 && pumps < 6; i++) begin
            @(posedge clk); #1;
            if (done_b) bad_done = 1;
            if (pump_on) pumps++;
        end
        req_b = 0;
        @(posedge clk); #1;
        checks++;
        if ({pump_on, liters_left, grant_b, done_b, busy} !== 8'd0) begin
            failures++;
            $display("[TB] FAIL abort_state got=%b expected=%b",
                     {pump_on, liters_left, grant_b, done_b, busy}, 8'd0);
        end
        @(posedge clk); #1;
        checks++;
        if ({grant_a, grant_b, done_b} !== 3'b100 || bad_done || pumps != 6) begin
            failures++;
            $display("[TB] FAIL abort_pending_a got=%b/pumps%0d expected=100/pumps6",
                     {grant_a, grant_b, done_b}, pumps);
        end
    endtask

    task automatic test_reset_mid_pump();
        bit got_pump = 0;
        apply_reset();
        req_a = 1; vol_a = 1;
        for (int i = 0; i < 10 && !got_pump; i++) begin
            @(posedge clk); #1;
            if (pump_on) got_pump = 1;
        end
        repeat (3) @(posedge clk);
        #4;
        reset = 0;
        #1;
        checks++;
        if (!got_pump || {grant_a, grant_b, done_a, done_b, pump_on, busy, liters_left} !== 10'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_pump got=%b pumped=%0d expected=%b",
                     {grant_a, grant_b, done_a, done_b, pump_on, busy, liters_left}, got_pump, 10'd0);
        end
        req_b = 1;
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        checks++;
        if ({grant_a, grant_b} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL post_reset_tie got=%b expected=10", {grant_a, grant_b});
        end
        repeat (3) @(posedge clk);
        #1;
        req_a = 0; req_b = 0;
        @(posedge clk); #1;
        @(negedge clk); req_a = 1; req_b = 1;
        @(posedge clk); #1;
        checks++;
        if ({grant_a, grant_b} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL tie_after_a_served got=%b expected=01", {grant_a, grant_b});
        end
    endtask

`ifdef AQUA_TANK_LEVEL_EN
    task automatic test_tank_level();
        bit seen = 0;
        apply_reset();
        #1;
        checks++;
        if (tank_level !== 8'd12) begin
            failures++;
            $display("[TB] FAIL tank_reset got=%0d expected=12", tank_level);
        end
        req_a = 1; vol_a = 1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            if (done_a) seen = 1;
        end
        req_a = 0;
        checks++;
        if (!seen || tank_level !== 8'd2) begin
            failures++;
            $display("[TB] FAIL tank_after_10 got=%0d done=%0d expected=2", tank_level, seen);
        end
        @(negedge clk); @(negedge clk);
        req_a = 1; vol_a = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({reject_a, reject_b, grant_a, pump_on} !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL tank_reject got=%b expected=1000", {reject_a, reject_b, grant_a, pump_on});
        end
        req_a = 0; refill = 1;
        @(negedge clk); refill = 0; req_a = 1;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk); #1;
            if (done_a) seen = 1;
        end
        req_a = 0;
        checks++;
        if (!seen || tank_level !== 8'd7) begin
            failures++;
            $display("[TB] FAIL tank_after_refill got=%0d done=%0d expected=7", tank_level, seen);
        end
    endtask
`endif

    task automatic test_random();
        logic [9:0] exp_v;
        logic [9:0] act_v;
        apply_reset();
`ifdef AQUA_TANK_LEVEL_EN
        refill = 1;
`endif
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (req_a) begin
                if ($urandom_range(0, 63) == 0 || (m_done_a && $urandom_range(0, 1) == 0)) req_a = 0;
            end else if ($urandom_range(0, 7) == 0) begin
                req_a = 1;
            end
            if (req_b) begin
                if ($urandom_range(0, 63) == 0 || (m_done_b && $urandom_range(0, 1) == 0)) req_b = 0;
            end else if ($urandom_range(0, 7) == 0) begin
                req_b = 1;
            end
            vol_a = 1'($urandom_range(0, 1));
            vol_b = 1'($urandom_range(0, 1));
            @(posedge clk);
            model_step();
            #1;
            exp_v = {m_grant_a, m_grant_b, m_done_a, m_done_b, m_pump, (m_phase != P_IDLE), 4'(m_liters)};
            act_v = {grant_a, grant_b, done_a, done_b, pump_on, busy, liters_left};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL rand_cycle%0d outputs got=%b expected=%b", cyc, act_v, exp_v);
            end
            checks++;
            if ((grant_a && grant_b) || (done_a && !grant_a) || (done_b && !grant_b)) begin
                failures++;
                $display("[TB] FAIL rand_exclusive cycle%0d got=%b expected=single_owner", cyc, act_v);
            end
        end
        req_a = 0; req_b = 0;
    endtask

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_single_dispense();
        test_back_to_back();
        test_abort();
        test_reset_mid_pump();
`ifdef AQUA_TANK_LEVEL_EN
        test_tank_level();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
